// File: rtl/hadamard_butterfly_pipe.sv
// Three-stage complex Hadamard butterfly: out0 = (a+b)/sqrt2, out1 = (a-b)/sqrt2.
// Signed Q-format operands, round half toward +inf, saturating outputs, saturation event counter.
module hadamard_butterfly_pipe #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int ISQ2     = 46341,
  parameter int SATCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] o0_re,
  output logic signed [DATA_W-1:0] o0_im,
  output logic signed [DATA_W-1:0] o1_re,
  output logic signed [DATA_W-1:0] o1_im,
  output logic                     o_sat,
  output logic [SATCNT_W-1:0]      sat_cnt,
  input  logic                     sat_clr
);

  localparam int SW = DATA_W + 1;
  localparam int PW = DATA_W + FRAC_W + 2;
  localparam int RW = PW - FRAC_W;

  localparam logic [FRAC_W:0]        ISQ2_U = (FRAC_W + 1)'(ISQ2);
  localparam logic signed [PW-1:0]   RND    = PW'(1) << (FRAC_W - 1);
  localparam logic signed [RW-1:0]   MAXV   = RW'({1'b0, {(DATA_W - 1){1'b1}}});
  localparam logic signed [RW-1:0]   MINV   = ~MAXV;

  // Handshake: a transfer happens on a clock edge where valid and ready are both 1.
  // A stage loads when it is empty or its content moves on in the same edge, so
  // bubbles collapse and a full pipe streams when out_ready=1.
  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3       = !v3 | out_ready;
  assign ld2       = !v2 | ld3;
  assign ld1       = !v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  logic signed [SW-1:0] s_re, s_im, d_re, d_im;
  logic signed [PW-1:0] p_re, p_im, q_re, q_im;
  logic [DATA_W:0]      r0_re, r0_im, r1_re, r1_im;

  // ISQ2 is zero-extended so the multiply is signed x positive.
  function automatic logic signed [PW-1:0] scale(input logic signed [SW-1:0] x);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ke;
    xe = PW'(x);
    ke = signed'(PW'(ISQ2_U));
    return xe * ke;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [DATA_W:0] rnd_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    logic signed [RW-1:0] r;
    t = p + RND;
    r = RW'(t >>> FRAC_W);
    if (r > MAXV)      return {1'b1, MAXV[DATA_W-1:0]};
    else if (r < MINV) return {1'b1, MINV[DATA_W-1:0]};
    else               return {1'b0, r[DATA_W-1:0]};
  endfunction

  assign r0_re = rnd_sat(p_re);
  assign r0_im = rnd_sat(p_im);
  assign r1_re = rnd_sat(q_re);
  assign r1_im = rnd_sat(q_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s_re <= '0;
      s_im <= '0;
      d_re <= '0;
      d_im <= '0;
    end else if (ld1) begin
      v1   <= in_valid;
      s_re <= SW'(a_re) + SW'(b_re);
      s_im <= SW'(a_im) + SW'(b_im);
      d_re <= SW'(a_re) - SW'(b_re);
      d_im <= SW'(a_im) - SW'(b_im);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      p_re <= '0;
      p_im <= '0;
      q_re <= '0;
      q_im <= '0;
    end else if (ld2) begin
      v2   <= v1;
      p_re <= scale(s_re);
      p_im <= scale(s_im);
      q_re <= scale(d_re);
      q_im <= scale(d_im);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      o0_re <= '0;
      o0_im <= '0;
      o1_re <= '0;
      o1_im <= '0;
      o_sat <= 1'b0;
    end else if (ld3) begin
      v3    <= v2;
      o0_re <= r0_re[DATA_W-1:0];
      o0_im <= r0_im[DATA_W-1:0];
      o1_re <= r1_re[DATA_W-1:0];
      o1_im <= r1_im[DATA_W-1:0];
      o_sat <= r0_re[DATA_W] | r0_im[DATA_W] | r1_re[DATA_W] | r1_im[DATA_W];
    end
  end

  // Clear wins over an increment in the same cycle; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (v3 && out_ready && o_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SATCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hadamard_butterfly_pipe.sv
// Bench for hadamard_butterfly_pipe: directed table, backpressure/reset/counter sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_hadamard_butterfly_pipe;

  localparam int W = 129;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, o_sat, sat_clr;
  logic signed [31:0] a_re, a_im, b_re, b_im;
  logic signed [31:0] o0_re, o0_im, o1_re, o1_im;
  logic [15:0] sat_cnt;

  logic in_ready2, out_valid2, o_sat2;
  logic signed [31:0] o0_re2, o0_im2, o1_re2, o1_im2;
  logic [1:0] sat_cnt2;

  logic [W-1:0] out_pack;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int m_cnt16 = 0;
  int m_cnt2 = 0;

  assign out_pack = {o_sat, o0_re, o0_im, o1_re, o1_im};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hadamard_butterfly_pipe #(.DATA_W(32), .FRAC_W(16), .ISQ2(46341), .SATCNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .o0_re(o0_re), .o0_im(o0_im), .o1_re(o1_re), .o1_im(o1_im),
    .o_sat(o_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  hadamard_butterfly_pipe #(.DATA_W(32), .FRAC_W(16), .ISQ2(46341), .SATCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid2), .out_ready(out_ready),
    .o0_re(o0_re2), .o0_im(o0_im2), .o1_re(o1_re2), .o1_im(o1_im2),
    .o_sat(o_sat2), .sat_cnt(sat_cnt2), .sat_clr(sat_clr)
  );

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [32:0] comp(input longint x);
    longint r;
    r = floor_div(x * 46341 + 32768, 65536);
    if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, r[31:0]};
  endfunction

  function automatic logic [W-1:0] model(input logic signed [31:0] ar, ai, br, bi);
    logic [32:0] c0r, c0i, c1r, c1i;
    c0r = comp(longint'(ar) + longint'(br));
    c0i = comp(longint'(ai) + longint'(bi));
    c1r = comp(longint'(ar) - longint'(br));
    c1i = comp(longint'(ai) - longint'(bi));
    return {c0r[32] | c0i[32] | c1r[32] | c1i[32], c0r[31:0], c0i[31:0], c1r[31:0], c1i[31:0]};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 200000)) - 32'd100000;
      2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return {16'h0, 16'($urandom())};
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic r, input logic [31:0] ar, ai, br, bi,
                       output logic acc, output logic ir);
    in_valid  = v;
    out_ready = r;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    @(negedge clk);
    ir  = in_ready;
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(ar, ai, br, bi));
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic xfer_sat;
    xfer_sat = 1'b0;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", W'(out_valid), W'(1'b0));
      end else begin
        chk("out_data", out_pack, exp_q[0]);
        if (out_ready) begin
          e = exp_q.pop_front();
          rx_cnt++;
          xfer_sat = e[128];
        end
      end
    end
    if (!rst) begin
      if (sat_clr) begin
        m_cnt16 = 0;
        m_cnt2  = 0;
      end else if (xfer_sat) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic signed [31:0] ar, ai, br, bi;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[6];
  logic acc, ir;
  int sc, k, rx0, acc_n;
  logic [31:0] pa[5][4];
  logic pend;
  logic [31:0] cr, ci, dr, di;

  initial begin
    tbl[0] = '{32'sd65536, 32'sd0, 32'sd65536, 32'sd0, {1'b0, 32'd92682, 32'd0, 32'd0, 32'd0}};
    tbl[1] = '{32'sd1, 32'sd0, 32'sd0, 32'sd0, {1'b0, 32'd1, 32'd0, 32'd1, 32'd0}};
    tbl[2] = '{-32'sd1, 32'sd0, 32'sd0, 32'sd0, {1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0}};
    tbl[3] = '{32'h7FFF_FFFF, 32'sd0, 32'h7FFF_FFFF, 32'sd0, {1'b1, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0}};
    tbl[4] = '{32'h8000_0000, 32'sd0, 32'h8000_0000, 32'sd0, {1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd0}};
    tbl[5] = '{32'sd0, 32'sd65536, 32'sd0, -32'sd65536, {1'b0, 32'd0, 32'd0, 32'd0, 32'd92682}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_outputs", out_pack, W'(0));
    chk("rst_sat_cnt", W'(sat_cnt), W'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    @(posedge clk); #1;

    // directed table with exact latency
    sc = 0;
    foreach (tbl[i]) begin
      sc += int'(tbl[i].exp[128]);
      cycle(1'b1, 1'b1, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, acc, ir);
      chk("tbl_accept", W'(acc), W'(1'b1));
      cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
      @(negedge clk);
      chk("tbl_not_early", W'(out_valid), W'(1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_valid_n3", W'(out_valid), W'(1'b1));
      chk("tbl_result", out_pack, tbl[i].exp);
      @(posedge clk); #1;
      chk("tbl_sat_cnt", W'(sat_cnt), W'(sc));
      chk("tbl_sat_cnt2", W'(sat_cnt2), W'((sc > 3) ? 3 : sc));
    end

    // backpressure: out_ready low in cycles 2..8
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4; j++) pa[i][j] = rand_val();
    k = 0;
    rx0 = rx_cnt;
    for (int cyc = 0; cyc < 25; cyc++) begin
      int idx;
      idx = (k < 5) ? k : 0;
      cycle(k < 5, !(cyc >= 2 && cyc <= 8), pa[idx][0], pa[idx][1], pa[idx][2], pa[idx][3], acc, ir);
      if (cyc == 6) begin
        chk("bp_in_ready_low", W'(ir), W'(1'b0));
        chk("bp_held_entries", W'(k), W'(3));
      end
      if (acc) k++;
    end
    chk("bp_all_in", W'(k), W'(5));
    chk("bp_all_out", W'(rx_cnt - rx0), W'(5));

    // continuous streaming: one result per cycle
    rx0 = rx_cnt;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, rand_val(), rand_val(), rand_val(), rand_val(), acc, ir);
      acc_n += int'(acc);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    chk("stream_in", W'(acc_n), W'(20));
    chk("stream_out", W'(rx_cnt - rx0), W'(20));

    // randomized traffic with random backpressure and clears
    pend = 1'b0;
    cr = '0; ci = '0; dr = '0; di = '0;
    for (int i = 0; i < 300; i++) begin
      logic v;
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        cr = rand_val(); ci = rand_val(); dr = rand_val(); di = rand_val();
      end else begin
        v = 1'b1;
      end
      sat_clr = ($urandom_range(0, 29) == 0);
      cycle(v, $urandom_range(0, 3) != 0, cr, ci, dr, di, acc, ir);
      sat_clr = 1'b0;
      pend = v && !acc;
    end
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    chk("drain_empty", W'(exp_q.size()), W'(0));
    chk("rand_sat_cnt", W'(sat_cnt), W'(m_cnt16));
    chk("rand_sat_cnt2", W'(sat_cnt2), W'(m_cnt2));

    // asynchronous reset with pairs in flight
    cycle(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd5, 32'h7FFF_FFFF, 32'd7, acc, ir);
    cycle(1'b1, 1'b0, 32'd100, 32'd200, 32'd300, 32'd400, acc, ir);
    cycle(1'b0, 1'b0, '0, '0, '0, '0, acc, ir);
    chk("pre_rst_valid", W'(out_valid), W'(1'b1));
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_cnt16 = 0;
    m_cnt2 = 0;
    #1;
    chk("async_rst_valid", W'(out_valid), W'(1'b0));
    chk("async_rst_sat_cnt", W'(sat_cnt), W'(0));
    chk("async_rst_outputs", out_pack, W'(0));
    #1;
    rst = 1'b0;
    rx0 = rx_cnt;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    chk("no_stale_out", W'(rx_cnt - rx0), W'(0));

    // counter saturation and clear priority
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 32'h8000_0000, rand_val(), 32'h8000_0000, rand_val(), acc, ir);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    chk("cnt16_five", W'(sat_cnt), W'(5));
    chk("cnt2_sticks", W'(sat_cnt2), W'(3));
    cycle(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0, acc, ir);
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    chk("clr_pre_valid", W'(out_valid), W'(1'b1));
    sat_clr = 1'b1;
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, ir);
    sat_clr = 1'b0;
    chk("clr_priority", W'(sat_cnt), W'(0));
    chk("clr_priority2", W'(sat_cnt2), W'(0));
    chk("clr_model", W'(sat_cnt), W'(m_cnt16));
    chk("final_empty", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
